// File: rtl/vector_imm_broadcast_if.sv
// Request/response bundle for vector_imm_broadcast: decode-side request channel
// plus the beat-stream output toward the register file / ALU operand muxes.
interface vector_imm_broadcast_if #(
  parameter int unsigned LANES  = 8,
  parameter int unsigned N      = 32,
  parameter int unsigned IMM_W  = 10,
  parameter int unsigned BEAT_W = 4
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [IMM_W-1:0]     imm;
  logic [1:0]           mode;
  logic [7:0]           stride;
  logic [BEAT_W-1:0]    beats;
  logic                 out_valid;
  logic                 out_ready;
  logic [LANES*N-1:0]   out_data;
  logic [BEAT_W-1:0]    out_beat;
  logic                 out_last;

  modport master (
    output in_valid, imm, mode, stride, beats, out_ready,
    input  in_ready, out_valid, out_data, out_beat, out_last
  );

  modport slave (
    input  in_valid, imm, mode, stride, beats, out_ready,
    output in_ready, out_valid, out_data, out_beat, out_last
  );
endinterface

// File: rtl/vector_imm_broadcast.sv
// Broadcasts an instruction immediate into LANES x N-bit vectors (zext8/zext/sext/ramp),
// emitting 1..2**BEAT_W registered beats per request over a valid/ready stream.
module vector_imm_broadcast #(
  parameter int unsigned LANES  = 8,
  parameter int unsigned N      = 32,
  parameter int unsigned IMM_W  = 10,
  parameter int unsigned BEAT_W = 4
) (
  input logic                   clk,
  input logic                   rst,
  vector_imm_broadcast_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [1:0] M_ZEXT8 = 2'b00;
  localparam logic [1:0] M_ZEXT  = 2'b01;
  localparam logic [1:0] M_SEXT  = 2'b10;
  localparam logic [1:0] M_RAMP  = 2'b11;

  logic [0:0]        state;
  logic              ramp_l;
  logic [N-1:0]      stride_l;
  logic [N-1:0]      base;
  logic [BEAT_W-1:0] beats_l;

  logic [N-1:0]      imm_sext;
  logic [N-1:0]      stride_sext;
  logic [N-1:0]      imm_val;
  logic [N-1:0]      base_nxt;
  logic [BEAT_W-1:0] beat_nxt;

  function automatic logic [LANES*N-1:0] ramp_vec(input logic [N-1:0] b,
                                                  input logic [N-1:0] s);
    logic [LANES*N-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      v[i*N +: N] = b + N'(i) * s;
    end
    return v;
  endfunction

  always_comb begin
    imm_sext    = N'($signed(bus.imm));
    stride_sext = N'($signed(bus.stride));
    case (bus.mode)
      M_ZEXT8: imm_val = N'(bus.imm) & N'(8'hFF);
      M_ZEXT:  imm_val = N'(bus.imm);
      M_SEXT:  imm_val = imm_sext;
      default: imm_val = imm_sext;
    endcase
  end

  // Ramp advances incrementally: the next beat's lane 0 is base + LANES*stride.
  always_comb begin
    base_nxt = base + stride_l * N'(LANES);
    beat_nxt = bus.out_beat + BEAT_W'(1);
  end

  assign bus.in_ready = (state == IDLE) & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ramp_l        <= 1'b0;
      stride_l      <= '0;
      base          <= '0;
      beats_l       <= '0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_beat  <= '0;
      bus.out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            state         <= RUN;
            ramp_l        <= (bus.mode == M_RAMP);
            stride_l      <= stride_sext;
            base          <= imm_sext;
            beats_l       <= bus.beats;
            bus.out_valid <= 1'b1;
            bus.out_beat  <= '0;
            bus.out_last  <= (bus.beats == '0);
            bus.out_data  <= (bus.mode == M_RAMP) ? ramp_vec(imm_sext, stride_sext)
                                                  : {LANES{imm_val}};
          end
        end
        RUN: begin
          if (bus.out_ready) begin
            if (bus.out_last) begin
              state         <= IDLE;
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
            end else begin
              base         <= base_nxt;
              bus.out_beat <= beat_nxt;
              bus.out_last <= (beat_nxt == beats_l);
              if (ramp_l) begin
                bus.out_data <= ramp_vec(base_nxt, stride_l);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_imm_broadcast.sv
// Scoreboard bench for vector_imm_broadcast: stimulus queues expected beats,
// a negedge monitor pops and compares on every output handshake.
module tb_vector_imm_broadcast;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vector_imm_broadcast_if #(.LANES(8), .N(32), .IMM_W(10), .BEAT_W(4)) bus ();

  vector_imm_broadcast #(.LANES(8), .N(32), .IMM_W(10), .BEAT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [255:0] d;
    logic [3:0]   b;
    logic         l;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   checks = 0;
  int   passes = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] exp_lane(input logic [1:0] m, input logic [9:0] i,
                                           input logic [7:0] s, input int beat, input int lane);
    logic [31:0] si;
    logic [31:0] ss;
    si = {{22{i[9]}}, i};
    ss = {{24{s[7]}}, s};
    case (m)
      2'b00:   return {24'b0, i[7:0]};
      2'b01:   return {22'b0, i};
      2'b10:   return si;
      default: return si + 32'(beat * 8 + lane) * ss;
    endcase
  endfunction

  function automatic logic [255:0] exp_vec(input logic [1:0] m, input logic [9:0] i,
                                           input logic [7:0] s, input int beat);
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = exp_lane(m, i, s, beat, k);
    return v;
  endfunction

  task automatic push_model(input logic [1:0] m, input logic [9:0] i,
                            input logic [7:0] s, input logic [3:0] b);
    exp_t x;
    for (int k = 0; k <= int'(b); k++) begin
      x.d = exp_vec(m, i, s, k);
      x.b = 4'(k);
      x.l = (k == int'(b));
      sbq.push_back(x);
    end
  endtask

  task automatic push_const(input logic [31:0] lane, input logic [3:0] b);
    exp_t x;
    for (int k = 0; k <= int'(b); k++) begin
      x.d = {8{lane}};
      x.b = 4'(k);
      x.l = (k == int'(b));
      sbq.push_back(x);
    end
  endtask

  // Request is taken at the first posedge seen with in_ready high; inputs are then scrambled.
  task automatic send(input logic [1:0] m, input logic [9:0] i,
                      input logic [7:0] s, input logic [3:0] b);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.mode     = m;
    bus.imm      = i;
    bus.stride   = s;
    bus.beats    = b;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      $display("FAIL accept_timeout: in_ready %b after %0d cycles, required 1", bus.in_ready, n);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.mode     = ~m;
    bus.imm      = ~i;
    bus.stride   = ~s;
    bus.beats    = ~b;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sbq.size() != 0 || bus.out_valid !== 1'b0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      $display("FAIL drain_timeout: %0d beats pending, required 0", sbq.size());
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        $display("FAIL unexpected_beat: got beat %0d, required no beat", bus.out_beat);
      end else begin
        e = sbq.pop_front();
        chk("beat_data", bus.out_data, e.d);
        chk("beat_index", 256'(bus.out_beat), 256'(e.b));
        chk("beat_last", 256'(bus.out_last), 256'(e.l));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    logic [255:0] held;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.imm      = '0;
    bus.mode     = '0;
    bus.stride   = '0;
    bus.beats    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", 256'(bus.out_valid), 256'(0));
    chk("reset_out_data", bus.out_data, 256'(0));
    chk("reset_out_beat", 256'(bus.out_beat), 256'(0));
    chk("reset_out_last", 256'(bus.out_last), 256'(0));
    chk("reset_in_ready", 256'(bus.in_ready), 256'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 256'(bus.in_ready), 256'(1));

    // ZEXT8 single beat, one-cycle latency
    push_const(32'h000000A5, 4'd0);
    send(2'b00, 10'h3A5, 8'h00, 4'd0);
    @(negedge clk);
    chk("latency_out_valid", 256'(bus.out_valid), 256'(1));
    wait_drain();
    chk("back_to_idle", 256'(bus.in_ready), 256'(1));

    // SEXT / ZEXT variants
    push_const(32'hFFFFFFFF, 4'd0);
    send(2'b10, 10'h3FF, 8'h00, 4'd0);
    wait_drain();
    push_const(32'h000003FF, 4'd0);
    send(2'b01, 10'h3FF, 8'h00, 4'd0);
    wait_drain();
    push_const(32'h000003A5, 4'd1);
    send(2'b01, 10'h3A5, 8'h00, 4'd1);
    wait_drain();
    push_const(32'h00000155, 4'd0);
    send(2'b10, 10'h155, 8'h00, 4'd0);
    wait_drain();

    // RAMP two beats: 5,8,...,26 then 29,...,50
    push_model(2'b11, 10'd5, 8'd3, 4'd1);
    send(2'b11, 10'd5, 8'd3, 4'd1);
    wait_drain();

    // RAMP negative stride wraps through zero
    push_model(2'b11, 10'd0, 8'hFF, 4'd0);
    send(2'b11, 10'd0, 8'hFF, 4'd0);
    wait_drain();

    // Backpressure: hold beat 1 for three cycles
    push_model(2'b11, 10'h3F0, 8'h05, 4'd2);
    send(2'b11, 10'h3F0, 8'h05, 4'd2);
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    held = exp_vec(2'b11, 10'h3F0, 8'h05, 1);
    repeat (3) begin
      @(negedge clk);
      chk("hold_data", bus.out_data, held);
      chk("hold_beat", 256'(bus.out_beat), 256'(1));
      chk("hold_last", 256'(bus.out_last), 256'(0));
      chk("hold_valid", 256'(bus.out_valid), 256'(1));
      chk("busy_in_ready", 256'(bus.in_ready), 256'(0));
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_drain();

    // Reset mid-request at beat 2 of 4
    push_model(2'b11, 10'd7, 8'd1, 4'd3);
    send(2'b11, 10'd7, 8'd1, 4'd3);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    chk("pre_reset_beat", 256'(bus.out_beat), 256'(2));
    chk("pre_reset_pending", 256'(sbq.size()), 256'(2));
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", 256'(bus.out_valid), 256'(0));
    chk("rst_out_data", bus.out_data, 256'(0));
    chk("rst_out_beat", 256'(bus.out_beat), 256'(0));
    chk("rst_out_last", 256'(bus.out_last), 256'(0));
    chk("rst_in_ready", 256'(bus.in_ready), 256'(0));
    sbq.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 256'(bus.in_ready), 256'(1));
    push_const(32'h000000AA, 4'd1);
    send(2'b01, 10'h0AA, 8'h00, 4'd1);
    wait_drain();

    // Maximum request length: 16 beats
    push_const(32'h000000C3, 4'd15);
    send(2'b00, 10'h2C3, 8'h00, 4'd15);
    wait_drain();

    // Ramp under intermittent backpressure
    push_model(2'b11, 10'h200, 8'h80, 4'd5);
    send(2'b11, 10'h200, 8'h80, 4'd5);
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1 bus.out_ready = (k % 3 != 0);
    end
    bus.out_ready = 1'b1;
    wait_drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
